// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM encoding,
// datapath width, global truth/NOP constants and the packed stage-control bundle.
package pipeline_ctrl_pkg;

  localparam int XLEN = 32;

  localparam logic        TURE  = 1'b1;
  localparam logic        FALSE = 1'b0;
  localparam logic [31:0] NOP   = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LOAD_BUB = 2'd1,
    ST_DIV_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic bubble_ex;
    logic bubble_mem;
    logic bubble_wb;
    logic flush_id;
    logic div_go;
    logic redirect;
  } ctrl_t;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; o_hit flags the increment
// that lands exactly on LIMIT.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_hit
);

  localparam logic [WIDTH-1:0] PRE = LIMIT - WIDTH'(1);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))  r_cnt <= r_cnt + WIDTH'(1);
  end

  assign o_cnt = r_cnt;
  assign o_hit = i_inc && !i_clr && (r_cnt == PRE);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipe. Stage controls are
// combinational from state + inputs; state, counters and sticky flags are registered.
module pipeline_ctrl #(
  parameter int XLEN        = pipeline_ctrl_pkg::XLEN,
  parameter int MEM_TIMEOUT = 255,
  parameter int DIV_MAX     = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_hazerd_stall,
  input  logic            branch_taken_ex,
  input  logic [XLEN-1:0] branch_target_ex,
  input  logic            div_start_ex,
  input  logic            div_done,
  input  logic            dmem_req_mem,
  input  logic            dmem_ack,
  output logic            stall_if,
  output logic            stall_id,
  output logic            stall_ex,
  output logic            stall_mem,
  output logic            bubble_ex,
  output logic            bubble_mem,
  output logic            bubble_wb,
  output logic            flush_id,
  output logic            div_go,
  output logic            pc_redirect_en,
  output logic [XLEN-1:0] pc_redirect_addr,
  output logic            mem_timeout_err,
  output logic            div_timeout_err,
  output logic [31:0]     stall_cycles
);

  import pipeline_ctrl_pkg::*;

  localparam int MEM_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DIV_W = $clog2(DIV_MAX + 1);

  state_e r_state;
  state_e w_state_nxt;
  ctrl_t  w_ctrl;
  logic   r_done_seen;
  logic   r_mem_err;
  logic   r_div_err;

  logic             w_mem_wait;
  logic             w_div_fin;
  logic             w_in_div;
  logic             w_div_exit;
  logic [MEM_W-1:0] w_mem_cnt;
  logic [DIV_W-1:0] w_div_cnt;
  logic             w_mem_hit;
  logic             w_div_hit;
  logic             w_stall_hit;
  logic             w_unused;

  assign w_mem_wait = dmem_req_mem && !dmem_ack;
  assign w_in_div   = (r_state == ST_DIV_WAIT);
  assign w_div_fin  = div_done || r_done_seen;
  assign w_div_exit = w_in_div && (w_state_nxt != ST_DIV_WAIT);

  always_comb begin
    w_ctrl      = '0;
    w_state_nxt = r_state;
    if (w_mem_wait) begin
      // Memory wait freezes the whole front of the pipe and holds FSM state.
      w_ctrl.stall_if  = TURE;
      w_ctrl.stall_id  = TURE;
      w_ctrl.stall_ex  = TURE;
      w_ctrl.stall_mem = TURE;
      w_ctrl.bubble_wb = TURE;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (div_start_ex) begin
            w_ctrl.div_go     = TURE;
            w_ctrl.stall_if   = TURE;
            w_ctrl.stall_id   = TURE;
            w_ctrl.stall_ex   = TURE;
            w_ctrl.bubble_mem = TURE;
            w_state_nxt       = ST_DIV_WAIT;
          end else if (branch_taken_ex) begin
            w_ctrl.redirect  = TURE;
            w_ctrl.flush_id  = TURE;
            w_ctrl.bubble_ex = TURE;
          end else if (load_hazerd_stall) begin
            w_ctrl.stall_if  = TURE;
            w_ctrl.stall_id  = TURE;
            w_ctrl.bubble_ex = TURE;
            w_state_nxt      = ST_LOAD_BUB;
          end
        end
        ST_LOAD_BUB: begin
          // Second cycle of a load-use: the hazard is stale, only a branch acts.
          if (branch_taken_ex) begin
            w_ctrl.redirect  = TURE;
            w_ctrl.flush_id  = TURE;
            w_ctrl.bubble_ex = TURE;
          end
          w_state_nxt = ST_RUN;
        end
        ST_DIV_WAIT: begin
          if (w_div_fin) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_ctrl.stall_if   = TURE;
            w_ctrl.stall_id   = TURE;
            w_ctrl.stall_ex   = TURE;
            w_ctrl.bubble_mem = TURE;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  // While reset is held the pipe is forced to fill with NOPs.
  assign stall_if         = rst_n && w_ctrl.stall_if;
  assign stall_id         = rst_n && w_ctrl.stall_id;
  assign stall_ex         = rst_n && w_ctrl.stall_ex;
  assign stall_mem        = rst_n && w_ctrl.stall_mem;
  assign bubble_ex        = !rst_n || w_ctrl.bubble_ex;
  assign bubble_mem       = !rst_n || w_ctrl.bubble_mem;
  assign bubble_wb        = !rst_n || w_ctrl.bubble_wb;
  assign flush_id         = !rst_n || w_ctrl.flush_id;
  assign div_go           = rst_n && w_ctrl.div_go;
  assign pc_redirect_en   = rst_n && w_ctrl.redirect;
  assign pc_redirect_addr = branch_target_ex;
  assign mem_timeout_err  = r_mem_err;
  assign div_timeout_err  = r_div_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_done_seen <= FALSE;
      r_mem_err   <= FALSE;
      r_div_err   <= FALSE;
    end else begin
      r_state <= w_state_nxt;
      // A completion that lands under a memory wait is remembered until we leave.
      if (w_div_exit)
        r_done_seen <= FALSE;
      else if (w_in_div && w_mem_wait && div_done)
        r_done_seen <= TURE;
      if (w_mem_hit) r_mem_err <= TURE;
      if (w_div_hit) r_div_err <= TURE;
    end
  end

  sat_counter #(.WIDTH(MEM_W), .LIMIT(MEM_W'(MEM_TIMEOUT))) u_mem_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_mem_wait),
    .i_clr (!w_mem_wait),
    .o_cnt (w_mem_cnt),
    .o_hit (w_mem_hit)
  );

  sat_counter #(.WIDTH(DIV_W), .LIMIT(DIV_W'(DIV_MAX))) u_div_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_in_div),
    .i_clr (div_go),
    .o_cnt (w_div_cnt),
    .o_hit (w_div_hit)
  );

  sat_counter #(.WIDTH(32), .LIMIT(32'hFFFF_FFFF)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (stall_if),
    .i_clr (1'b0),
    .o_cnt (stall_cycles),
    .o_hit (w_stall_hit)
  );

  assign w_unused = ^{w_mem_cnt, w_div_cnt, w_stall_hit, NOP};

endmodule
